hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage WISC pipeline. It consumes the stage-register outputs downstream of decode (DX, XM, MW) plus the memory stall handshakes, and drives the stall/flush controls of the PC, FD, DX, XM and MW pipeline registers. It owns three pieces of state:
- the halt state;
- a wrong-path fetch squash flag for multi-cycle instruction memory;
- a bubble performance counter.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_ctrl_raw_cmp.sv | 19 +
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the WISC hazard/stall controller.
package hazard_pkg;

    // Controller state: running or halted until reset.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    // Width of a register-file index.
    localparam int REG_W = 3;

    // Default width of the saturating bubble counter.
    localparam int BUBBLE_CNT_W_DEF = 16;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_raw_cmp.sv
// Compares the decode-stage source registers against one in-flight
// destination. r0 is a real register, so index 0 matches like any other.
import hazard_pkg::*;

module raw_cmp (
    input  logic             rs_valid,
    input  logic             rt_valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             reg_write,
    input  logic [REG_W-1:0] write_reg,
    output logic             match
);

    assign match = reg_write &
                   ((rs_valid & (rs == write_reg)) |
                    (rt_valid & (rt == write_reg)));

endmodule : raw_cmp

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage WISC pipeline.
// Optional feature macro: HAZARD_FORWARD_EN. When defined, only load-use
// hazards against X stall decode; otherwise producers in X and M stall it.
// All control outputs are combinational from inputs and current state.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int BUBBLE_CNT_W = BUBBLE_CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    FD_rs_valid,
    input  logic                    FD_rt_valid,
    input  logic [REG_W-1:0]        FD_rs,
    input  logic [REG_W-1:0]        FD_rt,
    input  logic                    DX_regWrite,
    input  logic                    DX_memRead,
    input  logic [REG_W-1:0]        DX_writeReg,
    input  logic                    XM_regWrite,
    input  logic [REG_W-1:0]        XM_writeReg,
    input  logic                    MW_halt,
    input  logic                    X_redirect,
    input  logic                    imem_stall,
    input  logic                    dmem_stall,
    output logic                    pc_stall,
    output logic                    FD_stall,
    output logic                    DX_stall,
    output logic                    XM_stall,
    output logic                    FD_flush,
    output logic                    DX_flush,
    output logic                    MW_flush,
    output logic                    halted,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    state_e                  state;
    state_e                  state_nxt;
    logic                    squash_pend;
    logic                    squash_nxt;
    logic [BUBBLE_CNT_W-1:0] cnt_nxt;
    logic                    raw_hazard;

`ifdef HAZARD_FORWARD_EN
    // Forwarding covers X->M and M->W; only a load still in X must stall.
    logic unused_xm;
    assign unused_xm = XM_regWrite ^ (^XM_writeReg);

    raw_cmp u_cmp_dx (
        .rs_valid  (FD_rs_valid),
        .rt_valid  (FD_rt_valid),
        .rs        (FD_rs),
        .rt        (FD_rt),
        .reg_write (DX_regWrite & DX_memRead),
        .write_reg (DX_writeReg),
        .match     (raw_hazard)
    );
`else
    // Without forwarding any producer in X or M blocks decode; W is
    // covered by the register-file write-through bypass.
    logic match_dx;
    logic match_xm;
    logic unused_mr;
    assign unused_mr = DX_memRead;

    raw_cmp u_cmp_dx (
        .rs_valid  (FD_rs_valid),
        .rt_valid  (FD_rt_valid),
        .rs        (FD_rs),
        .rt        (FD_rt),
        .reg_write (DX_regWrite),
        .write_reg (DX_writeReg),
        .match     (match_dx)
    );

    raw_cmp u_cmp_xm (
        .rs_valid  (FD_rs_valid),
        .rt_valid  (FD_rt_valid),
        .rs        (FD_rs),
        .rt        (FD_rt),
        .reg_write (XM_regWrite),
        .write_reg (XM_writeReg),
        .match     (match_xm)
    );

    assign raw_hazard = match_dx | match_xm;
`endif

    // Next-state, squash flag, bubble counter and stall/flush outputs.
    always_comb begin
        pc_stall   = 1'b0;
        FD_stall   = 1'b0;
        DX_stall   = 1'b0;
        XM_stall   = 1'b0;
        FD_flush   = 1'b0;
        DX_flush   = 1'b0;
        MW_flush   = 1'b0;
        halted     = 1'b0;
        state_nxt  = state;
        squash_nxt = squash_pend;
        cnt_nxt    = bubble_cnt;
        case (state)
            HALTED: begin
                pc_stall = 1'b1;
                FD_stall = 1'b1;
                DX_stall = 1'b1;
                XM_stall = 1'b1;
                MW_flush = 1'b1;
                halted   = 1'b1;
            end
            RUN: begin
                if (MW_halt) begin
                    state_nxt = HALTED;
                end else begin
                    state_nxt = RUN;
                end
                if (dmem_stall) begin
                    // Freeze everything up to M; drain a bubble into W.
                    pc_stall = 1'b1;
                    FD_stall = 1'b1;
                    DX_stall = 1'b1;
                    XM_stall = 1'b1;
                    MW_flush = 1'b1;
                end else if (X_redirect) begin
                    // An outstanding fetch at redirect time is wrong-path.
                    FD_flush   = 1'b1;
                    DX_flush   = 1'b1;
                    squash_nxt = squash_pend | imem_stall;
                end else if (squash_pend && !imem_stall) begin
                    // Wrong-path fetch has completed: discard it.
                    FD_flush   = 1'b1;
                    squash_nxt = 1'b0;
                end else if (raw_hazard) begin
                    pc_stall = 1'b1;
                    FD_stall = 1'b1;
                    DX_flush = 1'b1;
                end else if (imem_stall) begin
                    pc_stall = 1'b1;
                    FD_flush = 1'b1;
                end else begin
                    pc_stall = 1'b0;
                end
                if ((FD_flush || DX_flush) && (bubble_cnt != {BUBBLE_CNT_W{1'b1}})) begin
                    cnt_nxt = bubble_cnt + {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt = bubble_cnt;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            squash_pend <= 1'b0;
            bubble_cnt  <= {BUBBLE_CNT_W{1'b0}};
        end else begin
            state       <= state_nxt;
            squash_pend <= squash_nxt;
            bubble_cnt  <= cnt_nxt;
        end
    end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus against a rule-level reference model. A second instance with a
// 4-bit counter shares the inputs to exercise saturation.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        FD_rs_valid, FD_rt_valid;
    logic [2:0]  FD_rs, FD_rt;
    logic        DX_regWrite, DX_memRead;
    logic [2:0]  DX_writeReg;
    logic        XM_regWrite;
    logic [2:0]  XM_writeReg;
    logic        MW_halt, X_redirect, imem_stall, dmem_stall;
    logic        pc_stall, FD_stall, DX_stall, XM_stall;
    logic        FD_flush, DX_flush, MW_flush, halted;
    logic [15:0] bubble_cnt;
    logic        pc_stall4, FD_stall4, DX_stall4, XM_stall4;
    logic        FD_flush4, DX_flush4, MW_flush4, halted4;
    logic [3:0]  bubble_cnt4;
    logic [7:0]  obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_halted;
    bit m_squash;
    int m_cnt;
    int m_cnt4;

    always #5 clk = ~clk;

    assign obs = {pc_stall, FD_stall, DX_stall, XM_stall, FD_flush, DX_flush, MW_flush, halted};

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .FD_rs_valid(FD_rs_valid), .FD_rt_valid(FD_rt_valid), .FD_rs(FD_rs), .FD_rt(FD_rt),
        .DX_regWrite(DX_regWrite), .DX_memRead(DX_memRead), .DX_writeReg(DX_writeReg),
        .XM_regWrite(XM_regWrite), .XM_writeReg(XM_writeReg), .MW_halt(MW_halt),
        .X_redirect(X_redirect), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_stall(pc_stall), .FD_stall(FD_stall), .DX_stall(DX_stall), .XM_stall(XM_stall),
        .FD_flush(FD_flush), .DX_flush(DX_flush), .MW_flush(MW_flush), .halted(halted),
        .bubble_cnt(bubble_cnt)
    );

    hazard_ctrl #(.BUBBLE_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .FD_rs_valid(FD_rs_valid), .FD_rt_valid(FD_rt_valid), .FD_rs(FD_rs), .FD_rt(FD_rt),
        .DX_regWrite(DX_regWrite), .DX_memRead(DX_memRead), .DX_writeReg(DX_writeReg),
        .XM_regWrite(XM_regWrite), .XM_writeReg(XM_writeReg), .MW_halt(MW_halt),
        .X_redirect(X_redirect), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_stall(pc_stall4), .FD_stall(FD_stall4), .DX_stall(DX_stall4), .XM_stall(XM_stall4),
        .FD_flush(FD_flush4), .DX_flush(DX_flush4), .MW_flush(MW_flush4), .halted(halted4),
        .bubble_cnt(bubble_cnt4)
    );

    // Does any valid decode source name register r?
    function automatic bit src_hits(logic [2:0] r);
        return (FD_rs_valid && FD_rs == r) || (FD_rt_valid && FD_rt == r);
    endfunction

    function automatic bit raw_model();
`ifdef HAZARD_FORWARD_EN
        return DX_memRead && DX_regWrite && src_hits(DX_writeReg);
`else
        return (DX_regWrite && src_hits(DX_writeReg)) || (XM_regWrite && src_hits(XM_writeReg));
`endif
    endfunction

    // Expected {pc,FD,DX,XM stall, FD,DX,MW flush, halted} from the priority rules.
    function automatic logic [7:0] exp_out();
        if (m_halted)                  return 8'b1111_0011;
        if (dmem_stall)                return 8'b1111_0010;
        if (X_redirect)                return 8'b0000_1100;
        if (m_squash && !imem_stall)   return 8'b0000_1000;
        if (raw_model())               return 8'b1100_0100;
        if (imem_stall)                return 8'b1000_1000;
        return 8'b0000_0000;
    endfunction

    // Clock one edge and advance the reference model with the pre-edge inputs.
    task automatic advance();
        logic [7:0] e;
        e = exp_out();
        @(posedge clk);
        if (rst) begin
            m_halted = 1'b0;
            m_squash = 1'b0;
            m_cnt    = 0;
            m_cnt4   = 0;
        end else if (!m_halted) begin
            if (e[3] || e[2]) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15)   m_cnt4++;
            end
            if (dmem_stall)                   m_squash = m_squash;
            else if (X_redirect)              m_squash = m_squash || imem_stall;
            else if (m_squash && !imem_stall) m_squash = 1'b0;
            if (MW_halt) m_halted = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; FD_rs_valid = 1'b0; FD_rt_valid = 1'b0; FD_rs = 3'd0; FD_rt = 3'd0;
        DX_regWrite = 1'b0; DX_memRead = 1'b0; DX_writeReg = 3'd0;
        XM_regWrite = 1'b0; XM_writeReg = 3'd0; MW_halt = 1'b0;
        X_redirect = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 8'h00); end
        n_checks++;
        if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
        n_checks++;
        if (bubble_cnt4 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt4: got %0d want 0", bubble_cnt4); end
    endtask

    task automatic test_raw();
        logic [15:0] c0;
        idle();
        c0 = bubble_cnt;
        // Load in X writing r3, decode reads r3
        DX_memRead = 1'b1; DX_regWrite = 1'b1; DX_writeReg = 3'd3; FD_rs = 3'd3; FD_rs_valid = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'b1100_0100) begin n_fail++; $display("FAIL load_use: got %b want %b", obs, 8'b1100_0100); end
        advance();
        // Load now in M; bubble in X
        DX_memRead = 1'b0; DX_regWrite = 1'b0; XM_regWrite = 1'b1; XM_writeReg = 3'd3;
        #1;
        n_checks++;
        if (obs !== exp_out()) begin n_fail++; $display("FAIL load_in_m: got %b want %b", obs, exp_out()); end
        n_checks++;
        if (bubble_cnt !== c0 + 16'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d want %0d", bubble_cnt, c0 + 16'd1); end
        advance();
        // Producer in M writing r5, decode reads r5 via rt
        idle();
        XM_regWrite = 1'b1; XM_writeReg = 3'd5; FD_rt = 3'd5; FD_rt_valid = 1'b1;
        #1;
`ifdef HAZARD_FORWARD_EN
        n_checks++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL xm_fwd: got %b want %b", obs, 8'h00); end
`else
        n_checks++;
        if (obs !== 8'b1100_0100) begin n_fail++; $display("FAIL xm_raw: got %b want %b", obs, 8'b1100_0100); end
`endif
        FD_rt_valid = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL xm_invalid_src: got %b want %b", obs, 8'h00); end
        advance();
        // r0 is a real register
        idle();
        DX_memRead = 1'b1; DX_regWrite = 1'b1; DX_writeReg = 3'd0; FD_rt = 3'd0; FD_rt_valid = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'b1100_0100) begin n_fail++; $display("FAIL r0_match: got %b want %b", obs, 8'b1100_0100); end
        advance();
        idle();
    endtask

    task automatic test_redirect_squash();
        logic [7:0] want [5];
        logic       imem [5];
        want = '{8'b0000_1100, 8'b1000_1000, 8'b1000_1000, 8'b0000_1000, 8'b0000_0000};
        imem = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        idle();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 0) begin
                DX_memRead = 1'b1; DX_regWrite = 1'b1; DX_writeReg = 3'd2; FD_rs = 3'd2; FD_rs_valid = 1'b1;
                X_redirect = 1'b1;
            end
            imem_stall = imem[i];
            #1;
            n_checks++;
            if (obs !== want[i]) begin n_fail++; $display("FAIL squash_step%0d: got %b want %b", i, obs, want[i]); end
            n_checks++;
            if (bubble_cnt !== m_cnt[15:0]) begin n_fail++; $display("FAIL squash_cnt%0d: got %0d want %0d", i, bubble_cnt, m_cnt); end
            advance();
        end
    endtask

    task automatic test_dmem_redirect();
        idle();
        dmem_stall = 1'b1; X_redirect = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'b1111_0010) begin n_fail++; $display("FAIL dmem_hold: got %b want %b", obs, 8'b1111_0010); end
        advance();
        dmem_stall = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'b0000_1100) begin n_fail++; $display("FAIL dmem_redirect_after: got %b want %b", obs, 8'b0000_1100); end
        advance();
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle();
            FD_rs = 3'($urandom_range(0, 3)); FD_rt = 3'($urandom_range(0, 3));
            FD_rs_valid = 1'($urandom_range(0, 1)); FD_rt_valid = 1'($urandom_range(0, 1));
            DX_regWrite = 1'($urandom_range(0, 1)); DX_memRead = 1'($urandom_range(0, 1));
            DX_writeReg = 3'($urandom_range(0, 3));
            XM_regWrite = 1'($urandom_range(0, 1)); XM_writeReg = 3'($urandom_range(0, 3));
            dmem_stall = ($urandom_range(0, 7) == 0);
            X_redirect = ($urandom_range(0, 5) == 0);
            imem_stall = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 63) == 0);
            #1;
            n_checks++;
            if (obs !== exp_out()) begin n_fail++; $display("FAIL rand_out cyc%0d: got %b want %b", i, obs, exp_out()); end
            n_checks++;
            if (bubble_cnt !== m_cnt[15:0]) begin n_fail++; $display("FAIL rand_cnt cyc%0d: got %0d want %0d", i, bubble_cnt, m_cnt); end
            n_checks++;
            if (bubble_cnt4 !== m_cnt4[3:0]) begin n_fail++; $display("FAIL rand_cnt4 cyc%0d: got %0d want %0d", i, bubble_cnt4, m_cnt4); end
            advance();
        end
        idle();
    endtask

    task automatic test_saturate();
        idle();
        rst = 1'b1;
        advance();
        idle();
        for (int i = 0; i < 20; i++) begin
            X_redirect = 1'b1;
            #1;
            n_checks++;
            if (bubble_cnt4 !== m_cnt4[3:0]) begin n_fail++; $display("FAIL sat_cnt4 step%0d: got %0d want %0d", i, bubble_cnt4, m_cnt4); end
            advance();
        end
        idle();
        #1;
        n_checks++;
        if (bubble_cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_final4: got %0d want 15", bubble_cnt4); end
        n_checks++;
        if (bubble_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_final16: got %0d want 20", bubble_cnt); end
    endtask

    task automatic test_halt();
        logic [15:0] c0;
        idle();
        MW_halt = 1'b1; X_redirect = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'b0000_1100) begin n_fail++; $display("FAIL halt_entry_cycle: got %b want %b", obs, 8'b0000_1100); end
        advance();
        c0 = bubble_cnt;
        for (int i = 0; i < 10; i++) begin
            idle();
            X_redirect = 1'($urandom_range(0, 1)); imem_stall = 1'($urandom_range(0, 1));
            dmem_stall = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (obs !== 8'b1111_0011) begin n_fail++; $display("FAIL halted_hold%0d: got %b want %b", i, obs, 8'b1111_0011); end
            n_checks++;
            if (bubble_cnt !== c0) begin n_fail++; $display("FAIL halted_cnt%0d: got %0d want %0d", i, bubble_cnt, c0); end
            advance();
        end
        idle();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL halt_reset_out: got %b want %b", obs, 8'h00); end
        n_checks++;
        if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL halt_reset_cnt: got %0d want 0", bubble_cnt); end
    endtask

    initial begin
        m_halted = 1'b0; m_squash = 1'b0; m_cnt = 0; m_cnt4 = 0;
        idle();
        #2;
        test_reset();
        test_raw();
        test_redirect_squash();
        test_dmem_redirect();
        test_random();
        test_saturate();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
